// File: rtl/ctrl_pipe_if.sv
// ID-stage inputs and per-stage control outputs of ctrl_pipe.
// ex_fwd_a/ex_fwd_b exist only when CTRL_PIPE_FWD_EN is defined.
interface ctrl_pipe_if #(
  parameter int RAW = 4,
  parameter int OPW = 4
);
  logic           id_valid;
  logic [OPW-1:0] id_opcode;
  logic [RAW-1:0] id_rs;
  logic [RAW-1:0] id_rt;
  logic [RAW-1:0] id_rd;
  logic           ex_redirect;
  logic           mem_ready;
  logic           id_stall;
  logic           ex_valid, ex_alu2mux, ex_zen, ex_ven, ex_nen;
  logic           mem_valid, mem_en, mem_wr;
  logic           wb_valid, wb_write_reg;
  logic [1:0]     wb_dst_mux;
  logic [RAW-1:0] wb_dst;
  logic           halted;
`ifdef CTRL_PIPE_FWD_EN
  logic [1:0]     ex_fwd_a, ex_fwd_b;
`endif

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, ex_redirect, mem_ready,
    output id_stall, ex_valid, ex_alu2mux, ex_zen, ex_ven, ex_nen,
           mem_valid, mem_en, mem_wr, wb_valid, wb_write_reg, wb_dst_mux,
           wb_dst, halted
`ifdef CTRL_PIPE_FWD_EN
           , ex_fwd_a, ex_fwd_b
`endif
  );

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, ex_redirect, mem_ready,
    input  id_stall, ex_valid, ex_alu2mux, ex_zen, ex_ven, ex_nen,
           mem_valid, mem_en, mem_wr, wb_valid, wb_write_reg, wb_dst_mux,
           wb_dst, halted
`ifdef CTRL_PIPE_FWD_EN
           , ex_fwd_a, ex_fwd_b
`endif
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Pipelined control decoder: ID decode, EX/MEM/WB control registers, interlock, freeze, flush, halt.
// Define CTRL_PIPE_FWD_EN for forwarding selects with load-use-only stalls.
module ctrl_pipe #(
  parameter int RAW = 4,
  parameter int OPW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  ctrl_pipe_if.slave  bus
);
  typedef struct packed {
    logic       write;
    logic       alu2mux;
    logic       zen;
    logic       ven;
    logic       nen;
    logic       mem_en;
    logic       mem_wr;
    logic [1:0] dst_mux;
    logic       hlt;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  logic [3:0]     w_op;
  logic           w_op_ok, w_id_ok, w_use_rs, w_use_rt;
  ctrl_t          w_id_ctrl;
  logic           w_ex_hit_rs, w_ex_hit_rt, w_mem_hit_rs, w_mem_hit_rt;
  logic           w_hazard, w_halt, w_freeze, w_ex_bubble;

  logic           r_ex_valid;
  ctrl_t          r_ex_ctrl;
  logic [RAW-1:0] r_ex_dst;
  logic           r_mem_valid, r_mem_write, r_mem_en, r_mem_wr, r_mem_hlt;
  logic [1:0]     r_mem_dst_mux;
  logic [RAW-1:0] r_mem_dst;
  logic           r_wb_valid, r_wb_write, r_wb_hlt;
  logic [1:0]     r_wb_dst_mux;
  logic [RAW-1:0] r_wb_dst;
  logic           r_halted;

  assign w_op = bus.id_opcode[3:0];

  // Opcodes with any upper bit set decode as bubbles.
  generate
    if (OPW > 4) begin : g_op_hi
      assign w_op_ok = ~|bus.id_opcode[OPW-1:4];
    end else begin : g_op_lo
      assign w_op_ok = 1'b1;
    end
  endgenerate

  assign w_id_ok = bus.id_valid & w_op_ok;

  always_comb begin
    w_id_ctrl = CTRL_NONE;
    case (w_op)
      4'h0, 4'h1: begin
        w_id_ctrl.write = 1'b1;
        w_id_ctrl.zen   = 1'b1;
        w_id_ctrl.ven   = 1'b1;
        w_id_ctrl.nen   = 1'b1;
      end
      4'h2: begin
        w_id_ctrl.write = 1'b1;
        w_id_ctrl.zen   = 1'b1;
      end
      4'h3, 4'h7: w_id_ctrl.write = 1'b1;
      4'h4, 4'h5, 4'h6: begin
        w_id_ctrl.write   = 1'b1;
        w_id_ctrl.alu2mux = 1'b1;
        w_id_ctrl.zen     = 1'b1;
      end
      4'h8: begin
        w_id_ctrl.write   = 1'b1;
        w_id_ctrl.mem_en  = 1'b1;
        w_id_ctrl.dst_mux = 2'b01;
      end
      4'h9: begin
        w_id_ctrl.mem_en = 1'b1;
        w_id_ctrl.mem_wr = 1'b1;
      end
      4'hA, 4'hB: begin
        w_id_ctrl.write   = 1'b1;
        w_id_ctrl.dst_mux = 2'b10;
      end
      4'hE: begin
        w_id_ctrl.write   = 1'b1;
        w_id_ctrl.dst_mux = 2'b11;
      end
      4'hF:    w_id_ctrl.hlt = 1'b1;
      default: w_id_ctrl = CTRL_NONE;
    endcase
  end

  assign w_use_rs = (w_op <= 4'h9) || (w_op == 4'hD);
  assign w_use_rt = (w_op <= 4'h3) || (w_op == 4'h7) || (w_op == 4'h9);

  // Bubbles carry zero controls, so write alone marks a valid producer.
  assign w_ex_hit_rs  = w_id_ok & w_use_rs & (bus.id_rs != '0) & r_ex_ctrl.write & (r_ex_dst == bus.id_rs);
  assign w_ex_hit_rt  = w_id_ok & w_use_rt & (bus.id_rt != '0) & r_ex_ctrl.write & (r_ex_dst == bus.id_rt);
  assign w_mem_hit_rs = w_id_ok & w_use_rs & (bus.id_rs != '0) & r_mem_write & (r_mem_dst == bus.id_rs);
  assign w_mem_hit_rt = w_id_ok & w_use_rt & (bus.id_rt != '0) & r_mem_write & (r_mem_dst == bus.id_rt);

`ifdef CTRL_PIPE_FWD_EN
  logic [1:0] w_fwd_a, w_fwd_b, r_ex_fwd_a, r_ex_fwd_b;

  assign w_fwd_a  = w_ex_hit_rs ? 2'b01 : (w_mem_hit_rs ? 2'b10 : 2'b00);
  assign w_fwd_b  = w_ex_hit_rt ? 2'b01 : (w_mem_hit_rt ? 2'b10 : 2'b00);
  // Only a load in EX cannot be forwarded in time.
  assign w_hazard = (w_ex_hit_rs | w_ex_hit_rt) & r_ex_ctrl.mem_en & r_ex_ctrl.write;
  assign bus.ex_fwd_a = r_ex_fwd_a;
  assign bus.ex_fwd_b = r_ex_fwd_b;
`else
  assign w_hazard = w_ex_hit_rs | w_ex_hit_rt | w_mem_hit_rs | w_mem_hit_rt;
`endif

  assign w_halt      = r_halted | (r_ex_valid & r_ex_ctrl.hlt) | (r_mem_valid & r_mem_hlt) | (r_wb_valid & r_wb_hlt);
  assign w_freeze    = r_mem_valid & r_mem_en & ~bus.mem_ready;
  assign w_ex_bubble = ~w_id_ok | bus.ex_redirect | w_halt | w_hazard;
  assign bus.id_stall = rst_n & (w_freeze | (~bus.ex_redirect & (w_halt | w_hazard)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_ctrl     <= CTRL_NONE;
      r_ex_dst      <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_hlt     <= 1'b0;
      r_mem_dst_mux <= 2'b00;
      r_mem_dst     <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_write    <= 1'b0;
      r_wb_hlt      <= 1'b0;
      r_wb_dst_mux  <= 2'b00;
      r_wb_dst      <= '0;
      r_halted      <= 1'b0;
`ifdef CTRL_PIPE_FWD_EN
      r_ex_fwd_a    <= 2'b00;
      r_ex_fwd_b    <= 2'b00;
`endif
    end else begin
      r_halted <= r_halted | (r_wb_valid & r_wb_hlt);
      if (w_freeze) begin
        r_wb_valid   <= 1'b0;
        r_wb_write   <= 1'b0;
        r_wb_hlt     <= 1'b0;
        r_wb_dst_mux <= 2'b00;
        r_wb_dst     <= '0;
      end else begin
        r_wb_valid    <= r_mem_valid;
        r_wb_write    <= r_mem_write;
        r_wb_hlt      <= r_mem_hlt;
        r_wb_dst_mux  <= r_mem_dst_mux;
        r_wb_dst      <= r_mem_dst;
        r_mem_valid   <= r_ex_valid;
        r_mem_write   <= r_ex_ctrl.write;
        r_mem_en      <= r_ex_ctrl.mem_en;
        r_mem_wr      <= r_ex_ctrl.mem_wr;
        r_mem_hlt     <= r_ex_ctrl.hlt;
        r_mem_dst_mux <= r_ex_ctrl.dst_mux;
        r_mem_dst     <= r_ex_dst;
        if (w_ex_bubble) begin
          r_ex_valid <= 1'b0;
          r_ex_ctrl  <= CTRL_NONE;
          r_ex_dst   <= '0;
`ifdef CTRL_PIPE_FWD_EN
          r_ex_fwd_a <= 2'b00;
          r_ex_fwd_b <= 2'b00;
`endif
        end else begin
          r_ex_valid <= 1'b1;
          r_ex_ctrl  <= w_id_ctrl;
          r_ex_dst   <= bus.id_rd;
`ifdef CTRL_PIPE_FWD_EN
          r_ex_fwd_a <= w_fwd_a;
          r_ex_fwd_b <= w_fwd_b;
`endif
        end
      end
    end
  end

  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_alu2mux   = r_ex_ctrl.alu2mux;
  assign bus.ex_zen       = r_ex_ctrl.zen;
  assign bus.ex_ven       = r_ex_ctrl.ven;
  assign bus.ex_nen       = r_ex_ctrl.nen;
  assign bus.mem_valid    = r_mem_valid;
  assign bus.mem_en       = r_mem_en;
  assign bus.mem_wr       = r_mem_wr;
  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_write_reg = r_wb_valid & r_wb_write;
  assign bus.wb_dst_mux   = r_wb_dst_mux;
  assign bus.wb_dst       = r_wb_dst;
  assign bus.halted       = r_halted;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: decode table, interlock, freeze, redirect, halt and reset.
// Build with CTRL_PIPE_FWD_EN defined to exercise the forwarding variant.
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;

  ctrl_pipe_if #(.RAW(4), .OPW(4)) bus ();
  ctrl_pipe #(.RAW(4), .OPW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

`ifdef CTRL_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Hand-derived decode expectations per opcode 0..E.
  logic [3:0] ex_tab  [0:14];  // {alu2mux, zen, ven, nen}
  logic [1:0] mem_tab [0:14];  // {mem_en, mem_wr}
  logic [2:0] wb_tab  [0:14];  // {write_reg, dst_mux}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, rs, rt, rd);
    bus.id_valid  = v;
    bus.id_opcode = op;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.id_rd     = rd;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.id_valid = 1'b0;
      #1;
    end
  endtask

  // Presents an instruction and holds it until id_stall drops; returns just before acceptance.
  task automatic issue(input logic [3:0] op, rs, rt, rd, output int stalls);
    stalls = 0;
    @(negedge clk);
    drive(1'b1, op, rs, rt, rd);
    #1;
    while (bus.id_stall && stalls < 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [3:0] op_v;
    ex_tab  = '{4'b0111, 4'b0111, 4'b0100, 4'b0000, 4'b1100, 4'b1100, 4'b1100, 4'b0000,
                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    mem_tab = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    wb_tab  = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                3'b101, 3'b000, 3'b110, 3'b110, 3'b000, 3'b000, 3'b111};

    rst_n = 1'b0;
    bus.ex_redirect = 1'b0;
    bus.mem_ready   = 1'b1;
    drive(1'b1, 4'h0, 4'h1, 4'h2, 4'h3);
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", bus.id_stall, 0);
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_wb", {bus.wb_valid, bus.wb_write_reg, bus.wb_dst_mux, bus.wb_dst}, 0);
    check("rst_halted", bus.halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.id_valid = 1'b0;
    #1;

    // Decode sweep: back-to-back opcodes 0..E, sources r0 so nothing interlocks.
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      op_v = 4'(j);
      if (j < 15) drive(1'b1, op_v, 4'h0, 4'h0, op_v + 4'h1);
      else bus.id_valid = 1'b0;
      #1;
      check($sformatf("dec_stall_%0d", j), bus.id_stall, 0);
      if (j >= 1 && j <= 15)
        check($sformatf("dec_ex_op%0h", j - 1),
              {bus.ex_valid, bus.ex_alu2mux, bus.ex_zen, bus.ex_ven, bus.ex_nen}, {1'b1, ex_tab[j-1]});
      if (j >= 2 && j <= 16)
        check($sformatf("dec_mem_op%0h", j - 2),
              {bus.mem_valid, bus.mem_en, bus.mem_wr}, {1'b1, mem_tab[j-2]});
      if (j >= 3 && j <= 17)
        check($sformatf("dec_wb_op%0h", j - 3),
              {bus.wb_valid, bus.wb_write_reg, bus.wb_dst_mux, bus.wb_dst},
              {1'b1, wb_tab[j-3], 4'(j - 2)});
    end

    // Three independent ADDs: WB writes on 3 consecutive cycles starting 3 cycles after issue.
    idle(3);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j < 3) drive(1'b1, 4'h0, 4'(3 * j + 2), 4'(3 * j + 3), 4'(3 * j + 1));
      else bus.id_valid = 1'b0;
      #1;
      check($sformatf("add3_stall_%0d", j), bus.id_stall, 0);
      check($sformatf("add3_wr_%0d", j), bus.wb_write_reg, (j >= 3 && j <= 5) ? 1 : 0);
      if (j >= 3 && j <= 5)
        check($sformatf("add3_dst_%0d", j), bus.wb_dst, 3 * (j - 3) + 1);
    end

    // ADD r3 then SUB r4,r3,r5.
    idle(3);
    issue(4'h0, 4'h1, 4'h2, 4'h3, s);
    check("raw_add_stalls", s, 0);
    issue(4'h1, 4'h3, 4'h5, 4'h4, s);
    check("raw_sub_stalls", s, FWD ? 0 : 2);
    idle(1);
    check("raw_sub_ex", {bus.ex_valid, bus.ex_ven}, 2'b11);
`ifdef CTRL_PIPE_FWD_EN
    check("raw_fwd_a", bus.ex_fwd_a, 2'b01);
    check("raw_fwd_b", bus.ex_fwd_b, 2'b00);
`endif

    // LW r2 then ADD r1,r2,r2 (load-use).
    idle(3);
    issue(4'h8, 4'h1, 4'h0, 4'h2, s);
    issue(4'h0, 4'h2, 4'h2, 4'h1, s);
    check("lu_stalls", s, FWD ? 1 : 2);
    idle(1);
    check("lu_add_ex", bus.ex_valid, 1);
`ifdef CTRL_PIPE_FWD_EN
    check("lu_fwd_ab", {bus.ex_fwd_a, bus.ex_fwd_b}, 4'b1010);
`endif

    // Writing r0 then reading r0 never interlocks.
    idle(3);
    issue(4'h0, 4'h1, 4'h2, 4'h0, s);
    issue(4'h1, 4'h0, 4'h0, 4'h5, s);
    check("r0_stalls", s, 0);

    // LW r6 with mem_ready low for 3 cycles while an ADD waits in ID.
    idle(3);
    issue(4'h8, 4'h1, 4'h0, 4'h6, s);
    idle(1);
    check("frz_lw_ex", bus.ex_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 4'h0, 4'hA, 4'hB, 4'h9);
      bus.mem_ready = 1'b0;
      #1;
      check($sformatf("frz_stall_%0d", i), bus.id_stall, 1);
      check($sformatf("frz_ex_hold_%0d", i), bus.ex_valid, 0);
      check($sformatf("frz_mem_hold_%0d", i), {bus.mem_valid, bus.mem_en}, 2'b11);
      check($sformatf("frz_wb_bubble_%0d", i), bus.wb_valid, 0);
    end
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    check("frz_release_stall", bus.id_stall, 0);
    check("frz_wb_bubble_3", bus.wb_valid, 0);
    idle(1);
    check("frz_wb_lw", {bus.wb_write_reg, bus.wb_dst_mux, bus.wb_dst}, {1'b1, 2'b01, 4'h6});
    check("frz_add_ex", bus.ex_valid, 1);
    check("frz_mem_after", bus.mem_valid, 0);

    // Taken branch in EX overrides a hazard on the ID instruction.
    idle(3);
    issue(4'h0, 4'h1, 4'h2, 4'h5, s);
    issue(4'hC, 4'h0, 4'h0, 4'h0, s);
    @(negedge clk);
    drive(1'b1, 4'h0, 4'h5, 4'h5, 4'h7);
    bus.ex_redirect = 1'b1;
    #1;
    check("br_in_ex", bus.ex_valid, 1);
    check("br_stall", bus.id_stall, 0);
    @(negedge clk);
    bus.ex_redirect = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    check("br_flush", bus.ex_valid, 0);

    // HLT: issue stops, halted rises 3 cycles after HLT enters EX and sticks.
    idle(3);
    issue(4'hF, 4'h0, 4'h0, 4'h0, s);
    check("hlt_issue_stalls", s, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      drive(1'b1, 4'h0, 4'h1, 4'h2, 4'h3);
      #1;
      check($sformatf("hlt_stall_%0d", i), bus.id_stall, 1);
      check($sformatf("hlt_ex_%0d", i), bus.ex_valid, (i == 1) ? 1 : 0);
      check($sformatf("hlt_halted_%0d", i), bus.halted, (i >= 4) ? 1 : 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("hlt_rst_stall", bus.id_stall, 0);
    check("hlt_before_edge", bus.halted, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.id_valid = 1'b0;
    #1;
    check("hlt_cleared", bus.halted, 0);
    check("hlt_rst_ex", bus.ex_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
